pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle CPU; the direct upstream neighbour of the PC incrementer (Adder).
- Holds the PC register and drives it to the incrementer's `a` input. The incrementer's `b` input is tied to 4 at the top level.
- Takes the incrementer's sum back as the sequential next PC.
- Chooses next PC from sequential, branch, jump/call and return sources. Includes a small circular return-address stack (RAS).

Parameters:
- WIDTH, 32, address width; must match the incrementer's size.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address stack entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the PC and the RAS this cycle.
- seq_pc  input  WIDTH  incrementer sum (pc + 4).
- branch_taken  input  1  conditional branch resolved taken.
- branch_target  input  WIDTH  branch destination.
- jump  input  1  unconditional jump.
- call  input  1  jump-and-link: jump to jump_target and push seq_pc.
- jump_target  input  WIDTH  jump/call destination.
- ret  input  1  return: pop the RAS and go to the popped address.
- pc  output  WIDTH  current PC; feeds instruction memory and incrementer `a`.
- pc_valid  output  1  PC is a fetchable address.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_overflow  output  1  sticky: a call was made while the RAS was full.
- ras_underflow  output  1  sticky: a ret was made while the RAS was empty.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_PC, pc_valid = 0.
  - RAS count = 0 and write pointer = 0, so ras_empty = 1 and ras_full = 0.
  - ras_overflow = ras_underflow = 0.
  - Reset asserted mid-operation drops all of this state immediately, independent of the clock.
- pc_valid rises on the first rising edge after rst_n deasserts. It stays 1 until the next reset.
- On that first edge pc keeps RESET_PC, and the RAS does not change. Control inputs are ignored on that edge.
- After that, on each edge, when stall = 1: pc, the RAS and the sticky flags all hold, and every control input is ignored.
- When stall = 0, the next PC is chosen by fixed priority:
  1. call → pc <= jump_target. Push seq_pc: write it at the write pointer, advance the pointer modulo RAS_DEPTH, and count = min(count + 1, RAS_DEPTH).
  2. jump → pc <= jump_target.
  3. ret, RAS not empty → pc <= top entry; move the pointer back by one modulo RAS_DEPTH; count - 1.
  4. ret, RAS empty → pc <= seq_pc; set ras_underflow; the RAS is unchanged.
  5. branch_taken → pc <= branch_target.
  6. otherwise → pc <= seq_pc.
- The top entry is the entry at (write pointer - 1) modulo RAS_DEPTH.
- Call while the RAS is full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_overflow is set.
- If call and ret are asserted together, call wins and ret is ignored; no pop occurs. If jump and ret are asserted together, jump wins.
- Sticky flags clear only on reset.
- Targets are used as given; no alignment masking. Addition wraps modulo 2^WIDTH; this happens inside the incrementer, and this block does no arithmetic.
- Latency: a control input sampled at edge N produces the new pc immediately after edge N. pc is registered and has no combinational path from the inputs.
- ras_empty and ras_full are decoded combinationally from the registered count.

Decomposition:
- Shared package (cpu_pkg): WIDTH default, RESET_PC, and the instruction-word increment constant 4 that ties off the incrementer's `b` input.
- One natural sub-module, ras_stack:
  - parameters WIDTH and RAS_DEPTH;
  - ports clk, rst_n, push, pop, push_data, top, empty, full;
  - circular pointer plus saturating count.
- pc_sequencer holds the PC register, priority mux, valid flag and sticky flags.

Test Plan:
- Reset/sequential: with RESET_PC = 0, release rst_n with the incrementer connected. Required: pc = 0 for two edges with pc_valid rising on the first; then 0x4, 0x8, 0xC on successive edges.
- Stall and branch: at pc = 0x8 assert stall for 3 cycles → pc holds at 0x8. Release stall with branch_taken = 1 and branch_target = 0x40 → pc = 0x40 after that edge.
- Call/return: at pc = 0x10 assert call with jump_target = 0x100 → pc = 0x100 and ras_empty = 0. Run 2 sequential cycles, then assert ret → pc = 0x14 and ras_empty = 1.
- Overflow: make 5 nested calls from 0x0, 0x100, 0x200, 0x300, 0x400. Required: ras_full = 1 after the 4th call and ras_overflow = 1 after the 5th. Then 4 rets return 0x404, 0x304, 0x204, 0x104, and ras_empty = 1.
- Underflow and conflicts: ret with the RAS empty at pc = 0x20 → pc = 0x24, ras_underflow = 1 and stays set. call + ret together at pc = 0x30 with jump_target = 0x80 → pc = 0x80 and one entry is pushed. jump + branch_taken → jump_target wins.
- Asynchronous reset mid-operation: with 2 RAS entries, assert rst_n low between edges. Required: pc = RESET_PC, ras_empty = 1 and flags = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch front end.
package cpu_pkg;

    localparam int unsigned XLEN              = 32;
    localparam logic [31:0] RESET_VECTOR      = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;
    localparam int unsigned RAS_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_RAS
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full.
module ras_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;

    assign top_ptr = wr_ptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);

    // Pointer wraps naturally since RAS_DEPTH is a power of two; count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and next-PC selection (sequential, branch, jump/call, return).
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned       WIDTH     = XLEN,
    parameter logic [WIDTH-1:0]  RESET_PC  = WIDTH'(RESET_VECTOR),
    parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [WIDTH-1:0] seq_pc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    logic             active;
    logic             push;
    logic             pop;
    logic             set_ovf;
    logic             set_unf;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] next_pc;
    pc_src_e          src;

    // The first edge after reset only raises pc_valid; controls are ignored.
    assign active = pc_valid & ~stall;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        src     = SRC_SEQ;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (call) begin
            src     = SRC_JUMP;
            push    = active;
            set_ovf = active & ras_full;
        end else if (jump) begin
            src = SRC_JUMP;
        end else if (ret) begin
            if (!ras_empty) begin
                src = SRC_RAS;
                pop = active;
            end else begin
                set_unf = active;
            end
        end else if (branch_taken) begin
            src = SRC_BRANCH;
        end
        case (src)
            SRC_BRANCH: next_pc = branch_target;
            SRC_JUMP:   next_pc = jump_target;
            SRC_RAS:    next_pc = ras_top;
            default:    next_pc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            pc_valid      <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (active) begin
                pc            <= next_pc;
                ras_overflow  <= ras_overflow | set_ovf;
                ras_underflow <= ras_underflow | set_unf;
            end
        end
    end

endmodule
